// File: rtl/btb_predictor_pkg.sv
// Shared types and constants for the branch target buffer.
// BTB_RAS_EN (optional) adds a return-address stack; see btb_predictor.sv.
package btb_predictor_pkg;

   typedef logic [31:0] word_t;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SWEEP = 1'b1;

   // Weak counter states: MSB set with the rest clear (weak taken), and its predecessor.
   function automatic int ctr_weak_t(input int bits);
      return 1 << (bits - 1);
   endfunction

   function automatic int ctr_weak_nt(input int bits);
      return (1 << (bits - 1)) - 1;
   endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch/resolve-side bundle for btb_predictor; master = pipeline, slave = predictor.
// The return-stack signals exist only when BTB_RAS_EN is defined.
interface btb_predictor_if;
   import btb_predictor_pkg::*;

   word_t lookup_pc;
   word_t predicted_pc;
   logic  pred_taken;
   logic  btb_hit;
   logic  upd_en;
   word_t upd_pc;
   word_t upd_target;
   logic  upd_taken;
   logic  flush;
   logic  busy;
`ifdef BTB_RAS_EN
   logic  lookup_is_ret;
   logic  upd_is_call;

   modport master (
      output lookup_pc, upd_en, upd_pc, upd_target, upd_taken, flush,
             lookup_is_ret, upd_is_call,
      input  predicted_pc, pred_taken, btb_hit, busy
   );
   modport slave (
      input  lookup_pc, upd_en, upd_pc, upd_target, upd_taken, flush,
             lookup_is_ret, upd_is_call,
      output predicted_pc, pred_taken, btb_hit, busy
   );
`else
   modport master (
      output lookup_pc, upd_en, upd_pc, upd_target, upd_taken, flush,
      input  predicted_pc, pred_taken, btb_hit, busy
   );
   modport slave (
      input  lookup_pc, upd_en, upd_pc, upd_target, upd_taken, flush,
      output predicted_pc, pred_taken, btb_hit, busy
   );
`endif

endinterface

// File: rtl/btb_predictor_ras.sv
// bp_ras: circular return-address stack; oldest entry is overwritten when full.
// Compiled only when BTB_RAS_EN is defined.
`ifdef BTB_RAS_EN
module bp_ras
   import btb_predictor_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  clear,
   input  logic  push,
   input  logic  pop,
   input  word_t push_data,
   output word_t top,
   output logic  empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   word_t         mem_q [DEPTH];
   logic [PW-1:0] ptr_q;
   logic [CW-1:0] count_q;
   logic [PW-1:0] ptr_inc;
   logic [PW-1:0] ptr_dec;
   logic          do_pop;

   assign ptr_inc = (ptr_q == LAST_PTR) ? '0 : ptr_q + PW'(1);
   assign ptr_dec = (ptr_q == '0) ? LAST_PTR : ptr_q - PW'(1);
   assign do_pop  = pop && (count_q != '0);
   assign top     = mem_q[ptr_q];
   assign empty   = (count_q == '0);

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else if (push && do_pop) begin
         // A return and a call retiring together leave depth unchanged.
         mem_q[ptr_q] <= push_data;
      end else if (push) begin
         ptr_q          <= ptr_inc;
         mem_q[ptr_inc] <= push_data;
         if (count_q != FULL_CNT) count_q <= count_q + CW'(1);
      end else if (do_pop) begin
         ptr_q   <= ptr_dec;
         count_q <= count_q - CW'(1);
      end
   end

endmodule
`endif

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters and a flush sweep.
// Define BTB_RAS_EN to add a return-address stack (bp_ras) ahead of the BTB path.
module btb_predictor
   import btb_predictor_pkg::*;
#(
   parameter int ENTRIES   = 16,
   parameter int CTR_BITS  = 2,
   parameter int RAS_DEPTH = 4
) (
   input logic            CLK,
   input logic            nRST,
   btb_predictor_if.slave bus
);
   localparam int IDXW = $clog2(ENTRIES);
   localparam int TAGW = 32 - IDXW - 2;
   localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(ctr_weak_t(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
   localparam logic [IDXW-1:0]     LAST_IDX    = IDXW'(ENTRIES - 1);

   if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
      $error("btb_predictor: ENTRIES must be a power of two >= 2");
   end
   if (CTR_BITS < 1) begin : g_bad_ctr
      $error("btb_predictor: CTR_BITS must be >= 1");
   end
   if (RAS_DEPTH < 1) begin : g_bad_ras
      $error("btb_predictor: RAS_DEPTH must be >= 1");
   end

   typedef struct packed {
      logic                valid;
      logic [TAGW-1:0]     tag;
      word_t               target;
      logic [CTR_BITS-1:0] ctr;
   } btb_entry_t;

   function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] c,
                                                    input logic taken);
      if (taken) return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
      return (c == '0) ? c : c - CTR_BITS'(1);
   endfunction

   btb_entry_t      table_q [ENTRIES];
   logic [0:0]      state_q;
   logic [IDXW-1:0] sweep_idx_q;

   logic            busy;
   logic            flush_start;
   logic            upd_ok;
   logic [IDXW-1:0] lk_idx;
   logic [TAGW-1:0] lk_tag;
   btb_entry_t      lk_entry;
   logic            lk_hit;
   logic            btb_taken;
   word_t           seq_pc;
   logic [IDXW-1:0] upd_idx;
   logic [TAGW-1:0] upd_tag;
   logic            upd_hit;

   assign busy        = (state_q == ST_SWEEP);
   assign flush_start = !busy && bus.flush;
   assign upd_ok      = !busy && !bus.flush && bus.upd_en;

   // Lookup: combinational read of the registered table, no write bypass.
   assign lk_idx    = bus.lookup_pc[IDXW+1:2];
   assign lk_tag    = bus.lookup_pc[31:IDXW+2];
   assign lk_entry  = table_q[lk_idx];
   assign lk_hit    = nRST && !busy && lk_entry.valid && (lk_entry.tag == lk_tag);
   assign btb_taken = lk_hit && lk_entry.ctr[CTR_BITS-1];
   assign seq_pc    = bus.lookup_pc + 32'd4;

   assign upd_idx = bus.upd_pc[IDXW+1:2];
   assign upd_tag = bus.upd_pc[31:IDXW+2];
   assign upd_hit = table_q[upd_idx].valid && (table_q[upd_idx].tag == upd_tag);

   // Tags and targets keep their contents across reset; only valid/ctr are cleared.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i].valid <= 1'b0;
            table_q[i].ctr   <= CTR_WEAK_NT;
         end
      end else if (busy) begin
         table_q[sweep_idx_q].valid <= 1'b0;
      end else if (upd_ok) begin
         if (upd_hit) begin
            table_q[upd_idx].ctr <= ctr_next(table_q[upd_idx].ctr, bus.upd_taken);
            if (bus.upd_taken) table_q[upd_idx].target <= bus.upd_target;
         end else begin
            table_q[upd_idx] <= '{valid:  1'b1,
                                  tag:    upd_tag,
                                  target: bus.upd_target,
                                  ctr:    bus.upd_taken ? CTR_WEAK_T : CTR_WEAK_NT};
         end
      end
   end

   // Flush sweep: one entry invalidated per cycle, ENTRIES cycles total.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= ST_IDLE;
         sweep_idx_q <= '0;
      end else if (state_q == ST_IDLE) begin
         if (bus.flush) begin
            state_q     <= ST_SWEEP;
            sweep_idx_q <= '0;
         end
      end else begin
         sweep_idx_q <= sweep_idx_q + IDXW'(1);
         if (sweep_idx_q == LAST_IDX) state_q <= ST_IDLE;
      end
   end

`ifdef BTB_RAS_EN
   logic  ras_push;
   logic  ras_pop;
   logic  ras_empty;
   word_t ras_top;

   assign ras_push = upd_ok && bus.upd_is_call;
   assign ras_pop  = nRST && !busy && bus.lookup_is_ret && !ras_empty;

   bp_ras #(.DEPTH(RAS_DEPTH)) u_ras (
      .clk       (CLK),
      .rst_n     (nRST),
      .clear     (flush_start),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (bus.upd_pc + 32'd4),
      .top       (ras_top),
      .empty     (ras_empty)
   );

   assign bus.pred_taken   = ras_pop || btb_taken;
   assign bus.predicted_pc = ras_pop ? ras_top : (btb_taken ? lk_entry.target : seq_pc);
`else
   assign bus.pred_taken   = btb_taken;
   assign bus.predicted_pc = btb_taken ? lk_entry.target : seq_pc;
`endif

   assign bus.btb_hit = lk_hit;
   assign bus.busy    = busy;

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed scenarios plus randomized traffic
// compared against a table-level reference model.
`timescale 1ns/1ps
module tb_btb_predictor;
   import btb_predictor_pkg::*;

   localparam int ENTRIES   = 16;
   localparam int CTR_BITS  = 2;
   localparam int RAS_DEPTH = 4;
   localparam int WEAK_T    = 1 << (CTR_BITS - 1);
   localparam int WEAK_NT   = WEAK_T - 1;
   localparam int CTR_TOP   = (1 << CTR_BITS) - 1;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;

   btb_predictor_if bus();

   btb_predictor #(.ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .RAS_DEPTH(RAS_DEPTH)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: one record per index, plus remaining busy cycles.
   bit          m_valid  [ENTRIES];
   int unsigned m_tag    [ENTRIES];
   int unsigned m_target [ENTRIES];
   int          m_ctr    [ENTRIES];
   int          m_busy_left = 0;

   function automatic int unsigned idx_of(input int unsigned pc);
      return (pc / 4) % ENTRIES;
   endfunction

   function automatic int unsigned tag_of(input int unsigned pc);
      return pc / (4 * ENTRIES);
   endfunction

   function automatic void model_pred(input int unsigned pc, output bit hit,
                                      output bit taken, output logic [31:0] next);
      int unsigned i;
      i     = idx_of(pc);
      hit   = nRST && (m_busy_left == 0) && m_valid[i] && (m_tag[i] == tag_of(pc));
      taken = hit && (m_ctr[i] >= WEAK_T);
      next  = taken ? m_target[i] : pc + 4;
   endfunction

   function automatic void model_edge();
      int unsigned i;
      if (!nRST) begin
         for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k] = 1'b0;
            m_ctr[k]   = WEAK_NT;
         end
         m_busy_left = 0;
      end else if (m_busy_left > 0) begin
         m_busy_left--;
      end else if (bus.flush) begin
         for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
         m_busy_left = ENTRIES;
      end else if (bus.upd_en) begin
         i = idx_of(bus.upd_pc);
         if (m_valid[i] && m_tag[i] == tag_of(bus.upd_pc)) begin
            if (bus.upd_taken) begin
               m_ctr[i]    = (m_ctr[i] < CTR_TOP) ? m_ctr[i] + 1 : CTR_TOP;
               m_target[i] = bus.upd_target;
            end else begin
               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
         end else begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = tag_of(bus.upd_pc);
            m_target[i] = bus.upd_target;
            m_ctr[i]    = bus.upd_taken ? WEAK_T : WEAK_NT;
         end
      end
   endfunction

   task automatic tick();
      model_edge();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_idle();
      bus.upd_en     = 1'b0;
      bus.upd_pc     = '0;
      bus.upd_target = '0;
      bus.upd_taken  = 1'b0;
      bus.flush      = 1'b0;
`ifdef BTB_RAS_EN
      bus.lookup_is_ret = 1'b0;
      bus.upd_is_call   = 1'b0;
`endif
   endtask

   task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      bus.upd_en     = 1'b1;
      bus.upd_pc     = pc;
      bus.upd_target = tgt;
      bus.upd_taken  = tk;
   endtask

   task automatic test_reset();
      drive_idle();
      bus.lookup_pc = 32'h100;
      nRST = 1'b0;
      tick();
      tick();
      #1;
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy);
      end
      n_vec++;
      if (bus.predicted_pc !== 32'h104 || bus.btb_hit !== 1'b0) begin
         n_err++; $display("FAIL reset_pred: got pc=%h hit=%b want pc=104 hit=0", bus.predicted_pc, bus.btb_hit);
      end
      nRST = 1'b1;
      tick();
      bus.lookup_pc = 32'h100;
      #1;
      n_vec++;
      if (bus.btb_hit !== 1'b0 || bus.pred_taken !== 1'b0 || bus.predicted_pc !== 32'h104) begin
         n_err++; $display("FAIL cold_lookup: got hit=%b tk=%b pc=%h want hit=0 tk=0 pc=104", bus.btb_hit, bus.pred_taken, bus.predicted_pc);
      end
   endtask

   task automatic test_train();
      bus.lookup_pc = 32'h300;
      drive_upd(32'h100, 32'h200, 1'b1);
      tick();
      drive_idle();
      bus.lookup_pc = 32'h100;
      #1;
      n_vec++;
      if (bus.btb_hit !== 1'b1 || bus.pred_taken !== 1'b1 || bus.predicted_pc !== 32'h200) begin
         n_err++; $display("FAIL train_taken: got hit=%b tk=%b pc=%h want hit=1 tk=1 pc=200", bus.btb_hit, bus.pred_taken, bus.predicted_pc);
      end
      drive_upd(32'h100, 32'h0, 1'b0);
      tick();
      #1;
      n_vec++;
      if (bus.btb_hit !== 1'b1 || bus.pred_taken !== 1'b0 || bus.predicted_pc !== 32'h104) begin
         n_err++; $display("FAIL train_nt1: got hit=%b tk=%b pc=%h want hit=1 tk=0 pc=104", bus.btb_hit, bus.pred_taken, bus.predicted_pc);
      end
      tick();
      drive_idle();
      #1;
      n_vec++;
      if (bus.btb_hit !== 1'b1 || bus.predicted_pc !== 32'h104) begin
         n_err++; $display("FAIL train_nt2: got hit=%b pc=%h want hit=1 pc=104", bus.btb_hit, bus.predicted_pc);
      end
   endtask

   task automatic test_alias();
      bus.lookup_pc = 32'h140;
      #1;
      n_vec++;
      if (bus.btb_hit !== 1'b0 || bus.predicted_pc !== 32'h144) begin
         n_err++; $display("FAIL alias_miss: got hit=%b pc=%h want hit=0 pc=144", bus.btb_hit, bus.predicted_pc);
      end
      bus.lookup_pc = 32'h103;
      #1;
      n_vec++;
      if (bus.btb_hit !== 1'b1) begin
         n_err++; $display("FAIL alias_orig_hit: got hit=%b want 1", bus.btb_hit);
      end
   endtask

   task automatic test_same_cycle();
      bus.lookup_pc = 32'h104;
      drive_upd(32'h104, 32'h400, 1'b1);
      #1;
      n_vec++;
      if (bus.btb_hit !== 1'b0 || bus.predicted_pc !== 32'h108) begin
         n_err++; $display("FAIL same_cycle_old: got hit=%b pc=%h want hit=0 pc=108", bus.btb_hit, bus.predicted_pc);
      end
      tick();
      drive_idle();
      #1;
      n_vec++;
      if (bus.btb_hit !== 1'b1 || bus.predicted_pc !== 32'h400) begin
         n_err++; $display("FAIL same_cycle_new: got hit=%b pc=%h want hit=1 pc=400", bus.btb_hit, bus.predicted_pc);
      end
   endtask

   task automatic test_flush();
      int busy_cnt;
      bus.lookup_pc = 32'h104;
      bus.flush = 1'b1;
      drive_upd(32'h108, 32'h500, 1'b1);
      tick();
      busy_cnt = 0;
      for (int c = 0; c < ENTRIES; c++) begin
         bus.flush = 1'($urandom_range(0, 1));
         drive_upd(32'h10C, 32'h600, 1'b1);
         bus.lookup_pc = 32'h104;
         #1;
         if (bus.busy === 1'b1) busy_cnt++;
         n_vec++;
         if (bus.btb_hit !== 1'b0 || bus.pred_taken !== 1'b0 || bus.predicted_pc !== 32'h108) begin
            n_err++; $display("FAIL flush_masked c=%0d: got hit=%b tk=%b pc=%h want hit=0 tk=0 pc=108", c, bus.btb_hit, bus.pred_taken, bus.predicted_pc);
         end
         tick();
      end
      drive_idle();
      #1;
      n_vec++;
      if (busy_cnt != ENTRIES || bus.busy !== 1'b0) begin
         n_err++; $display("FAIL flush_busy_len: got %0d busy cycles, busy_now=%b want %0d, 0", busy_cnt, bus.busy, ENTRIES);
      end
      for (int k = 0; k < 4; k++) begin
         bus.lookup_pc = 32'h100 + 32'(4 * k);
         #1;
         n_vec++;
         if (bus.btb_hit !== 1'b0) begin
            n_err++; $display("FAIL flush_cleared pc=%h: got hit=%b want 0", bus.lookup_pc, bus.btb_hit);
         end
      end
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      for (int c = 1; c < 5; c++) tick();
      #1;
      n_vec++;
      if (bus.busy !== 1'b1) begin
         n_err++; $display("FAIL sweep5_busy: got %b want 1", bus.busy);
      end
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      #1;
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_err++; $display("FAIL sweep_reset_abort: got busy=%b want 0", bus.busy);
      end
      tick();
      #1;
      n_vec++;
      if (bus.busy !== 1'b0) begin
         n_err++; $display("FAIL sweep_reset_stays: got busy=%b want 0", bus.busy);
      end
   endtask

   task automatic test_random();
      bit          e_hit, e_tk;
      logic [31:0] e_pc;
      for (int c = 0; c < 400; c++) begin
         drive_idle();
         nRST = ($urandom_range(0, 99) != 0);
         bus.lookup_pc = 32'($urandom_range(0, 2) * 64 + $urandom_range(0, ENTRIES - 1) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            drive_upd(32'($urandom_range(0, 2) * 64 + $urandom_range(0, ENTRIES - 1) * 4 + $urandom_range(0, 3)),
                      32'($urandom) & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
         bus.flush = ($urandom_range(0, 49) == 0);
         #1;
         model_pred(bus.lookup_pc, e_hit, e_tk, e_pc);
         n_vec++;
         if (bus.btb_hit !== e_hit || bus.pred_taken !== e_tk || bus.predicted_pc !== e_pc ||
             bus.busy !== (m_busy_left > 0)) begin
            n_err++;
            $display("FAIL random c=%0d pc=%h: got hit=%b tk=%b pc=%h busy=%b want hit=%b tk=%b pc=%h busy=%b",
                     c, bus.lookup_pc, bus.btb_hit, bus.pred_taken, bus.predicted_pc, bus.busy,
                     e_hit, e_tk, e_pc, m_busy_left > 0);
         end
         tick();
      end
      nRST = 1'b1;
      drive_idle();
   endtask

`ifdef BTB_RAS_EN
   task automatic test_ras();
      logic [31:0] want [4];
      want[0] = 32'h54; want[1] = 32'h44; want[2] = 32'h34; want[3] = 32'h24;
      drive_idle();
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      bus.lookup_pc = 32'h900;
      for (int k = 1; k <= 5; k++) begin
         drive_upd(32'(16 * k), 32'h1000, 1'b1);
         bus.upd_is_call = 1'b1;
         tick();
      end
      drive_idle();
      bus.lookup_is_ret = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_vec++;
         if (bus.pred_taken !== 1'b1 || bus.predicted_pc !== want[k]) begin
            n_err++; $display("FAIL ras_pop%0d: got tk=%b pc=%h want tk=1 pc=%h", k, bus.pred_taken, bus.predicted_pc, want[k]);
         end
         tick();
      end
      #1;
      n_vec++;
      if (bus.pred_taken !== 1'b0 || bus.predicted_pc !== 32'h904) begin
         n_err++; $display("FAIL ras_empty_fallback: got tk=%b pc=%h want tk=0 pc=904", bus.pred_taken, bus.predicted_pc);
      end
      drive_idle();
   endtask
`endif

   initial begin
      bus.lookup_pc = '0;
      drive_idle();
      test_reset();
      test_train();
      test_alias();
      test_same_cycle();
      test_flush();
      test_random();
`ifdef BTB_RAS_EN
      test_ras();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
